sram_port_arbiter: RTL and testbench

//  Parametrised N-channel arbiter + timing controller for one asynchronous SRAM bank (BaseRAM or ExtRAM).

---
 rtl/sram_port_arbiter_if.sv | 31 +++
 rtl/sram_port_arbiter.sv | 151 +++++++++++++++
 tb/tb_sram_port_arbiter.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/sram_port_arbiter_if.sv
// Requester-side bus of sram_port_arbiter: N_CH request channels packed side by side.
// Channel k occupies slice [k*W +: W] of every packed per-channel field.
interface sram_port_arbiter_if #(
  parameter int N_CH   = 2,
  parameter int ADDR_W = 20,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  // Handshake: a requester raises req_i[k] with we/be/addr/wdata stable and holds it until
  // gnt_o[k] pulses for one cycle (fields captured on that edge); req_i may be dropped
  // before a grant. ack_o[k] pulses once per granted access, and rdata_o is valid with it for reads.
  logic [N_CH-1:0]        req_i;
  logic [N_CH-1:0]        we_i;
  logic [N_CH*BE_W-1:0]   be_i;
  logic [N_CH*ADDR_W-1:0] addr_i;
  logic [N_CH*DATA_W-1:0] wdata_i;
  logic [N_CH-1:0]        gnt_o;
  logic [N_CH-1:0]        ack_o;
  logic [DATA_W-1:0]      rdata_o;

  modport master (
    output req_i, we_i, be_i, addr_i, wdata_i,
    input  gnt_o, ack_o, rdata_o
  );

  modport slave (
    input  req_i, we_i, be_i, addr_i, wdata_i,
    output gnt_o, ack_o, rdata_o
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// N-channel arbiter and strobe timing controller for one asynchronous SRAM bank.
// Optional macro SRAM_ARB_STATS_EN adds a saturating stall counter output (stall_cnt_o).
module sram_port_arbiter #(
  parameter int N_CH     = 2,
  parameter int ADDR_W   = 20,
  parameter int DATA_W   = 32,
  parameter int WAIT_CYC = 1,
  parameter int ARB_MODE = 0
) (
  input  logic                  clk,
  input  logic                  resetn,
  sram_port_arbiter_if.slave    bus,
  output logic                  busy_o,
  output logic [1:0]            state_o,
  output logic [ADDR_W-1:0]     ram_addr_o,
  output logic [DATA_W/8-1:0]   ram_be_n_o,
  output logic                  ram_ce_n_o,
  output logic                  ram_oe_n_o,
  output logic                  ram_we_n_o,
  output logic [DATA_W-1:0]     ram_data_o,
  output logic                  ram_data_oe,
  input  logic [DATA_W-1:0]     ram_data_i
`ifdef SRAM_ARB_STATS_EN
  ,
  output logic [31:0]           stall_cnt_o
`endif
);
  localparam int BE_W  = DATA_W / 8;
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int CNT_W = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_HOLD   = 2'd2
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [CH_W-1:0]   rr_ptr;
  logic [CH_W-1:0]   cur_ch;
  logic              cur_we;
  logic [CH_W-1:0]   win;
  logic              any_req;
  int                idx;
  logic [N_CH-1:0]   gnt;
  logic [N_CH-1:0]   ack;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] sel_addr;
  logic [BE_W-1:0]   sel_be;
  logic [DATA_W-1:0] sel_wdata;

  // Scanning from the far end lets the nearest hit in search order overwrite earlier ones.
  always_comb begin
    win     = '0;
    idx     = 0;
    any_req = |bus.req_i;
    if (ARB_MODE == 0) begin
      for (int i = N_CH - 1; i >= 0; i--) begin
        if (bus.req_i[CH_W'(i)]) win = CH_W'(i);
      end
    end else begin
      for (int i = N_CH; i >= 1; i--) begin
        idx = (int'(rr_ptr) + i) % N_CH;
        if (bus.req_i[CH_W'(idx)]) win = CH_W'(idx);
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (state == S_IDLE && any_req) gnt = N_CH'(1) << win;
    sel_addr  = bus.addr_i[win*ADDR_W +: ADDR_W];
    sel_be    = bus.be_i[win*BE_W +: BE_W];
    sel_wdata = bus.wdata_i[win*DATA_W +: DATA_W];
  end

  // The SRAM pin registers double as the request latch for the whole access.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= S_IDLE;
      cnt         <= '0;
      rr_ptr      <= CH_W'(N_CH - 1);
      cur_ch      <= '0;
      cur_we      <= 1'b0;
      ack         <= '0;
      rdata       <= '0;
      ram_addr_o  <= '0;
      ram_be_n_o  <= '1;
      ram_ce_n_o  <= 1'b1;
      ram_oe_n_o  <= 1'b1;
      ram_we_n_o  <= 1'b1;
      ram_data_o  <= '0;
      ram_data_oe <= 1'b0;
    end else begin
      ack <= '0;
      case (state)
        S_IDLE: begin
          if (any_req) begin
            state       <= S_ACCESS;
            cnt         <= '0;
            cur_ch      <= win;
            cur_we      <= bus.we_i[win];
            ram_addr_o  <= sel_addr;
            ram_be_n_o  <= ~sel_be;
            ram_data_o  <= sel_wdata;
            ram_data_oe <= bus.we_i[win];
            ram_ce_n_o  <= 1'b0;
            ram_oe_n_o  <= bus.we_i[win];
            ram_we_n_o  <= ~bus.we_i[win];
            if (ARB_MODE != 0) rr_ptr <= win;
          end
        end
        S_ACCESS: begin
          if (cnt == CNT_W'(WAIT_CYC - 1)) begin
            state      <= S_HOLD;
            ram_oe_n_o <= 1'b1;
            ram_we_n_o <= 1'b1;
            ack        <= N_CH'(1) << cur_ch;
            if (!cur_we) rdata <= ram_data_i;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_HOLD: begin
          state       <= S_IDLE;
          ram_ce_n_o  <= 1'b1;
          ram_be_n_o  <= '1;
          ram_data_oe <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef SRAM_ARB_STATS_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_cnt_o <= '0;
    end else if (((bus.req_i & ~gnt) != '0) && (stall_cnt_o != 32'hFFFF_FFFF)) begin
      stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`endif

  assign bus.gnt_o   = gnt;
  assign bus.ack_o   = ack;
  assign bus.rdata_o = rdata;
  assign busy_o      = (state != S_IDLE);
  assign state_o     = state;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: instance A (fixed priority, WAIT_CYC=1),
// instance B (round-robin, WAIT_CYC=3). Inputs driven 1 ns after posedge, outputs sampled on negedge.
module tb_sram_port_arbiter;
  localparam int NCH = 4;
  localparam int AW  = 20;
  localparam int DW  = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;
  int n_cmp = 0;
  int n_err = 0;

  sram_port_arbiter_if #(.N_CH(NCH), .ADDR_W(AW), .DATA_W(DW)) bus_a ();
  sram_port_arbiter_if #(.N_CH(NCH), .ADDR_W(AW), .DATA_W(DW)) bus_b ();

  logic          busy_a, ce_n_a, oe_n_a, we_n_a, doe_a;
  logic [1:0]    state_a;
  logic [AW-1:0] addr_a;
  logic [3:0]    be_n_a;
  logic [DW-1:0] dout_a, din_a;
  logic          busy_b, ce_n_b, oe_n_b, we_n_b, doe_b;
  logic [1:0]    state_b;
  logic [AW-1:0] addr_b;
  logic [3:0]    be_n_b;
  logic [DW-1:0] dout_b, din_b;
`ifdef SRAM_ARB_STATS_EN
  logic [31:0]   stall_a, stall_b;
  int            exp_stall_a = 0;
`endif

  sram_port_arbiter #(.N_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .WAIT_CYC(1), .ARB_MODE(0)) dut_a (
    .clk(clk), .resetn(rst_a), .bus(bus_a), .busy_o(busy_a), .state_o(state_a),
    .ram_addr_o(addr_a), .ram_be_n_o(be_n_a), .ram_ce_n_o(ce_n_a), .ram_oe_n_o(oe_n_a),
    .ram_we_n_o(we_n_a), .ram_data_o(dout_a), .ram_data_oe(doe_a), .ram_data_i(din_a)
`ifdef SRAM_ARB_STATS_EN
    , .stall_cnt_o(stall_a)
`endif
  );

  sram_port_arbiter #(.N_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .WAIT_CYC(3), .ARB_MODE(1)) dut_b (
    .clk(clk), .resetn(rst_b), .bus(bus_b), .busy_o(busy_b), .state_o(state_b),
    .ram_addr_o(addr_b), .ram_be_n_o(be_n_b), .ram_ce_n_o(ce_n_b), .ram_oe_n_o(oe_n_b),
    .ram_we_n_o(we_n_b), .ram_data_o(dout_b), .ram_data_oe(doe_b), .ram_data_i(din_b)
`ifdef SRAM_ARB_STATS_EN
    , .stall_cnt_o(stall_b)
`endif
  );

`ifdef SRAM_ARB_STATS_EN
  always @(negedge clk) begin
    if (!rst_a) exp_stall_a = 0;
    else if ((bus_a.req_i & ~bus_a.gnt_o) != '0) exp_stall_a++;
  end
`endif

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int oe_low;
    int acks;
    rst_a = 1'b0;
    rst_b = 1'b0;
    din_a = '0;
    din_b = '0;
    bus_a.req_i = '0; bus_a.we_i = '0; bus_a.be_i = '0; bus_a.addr_i = '0; bus_a.wdata_i = '0;
    bus_b.req_i = '0; bus_b.we_i = '0; bus_b.be_i = '0; bus_b.addr_i = '0; bus_b.wdata_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ce_n", 64'(ce_n_a), 64'h1);
    check("rst_oe_n", 64'(oe_n_a), 64'h1);
    check("rst_we_n", 64'(we_n_a), 64'h1);
    check("rst_be_n", 64'(be_n_a), 64'hF);
    check("rst_addr", 64'(addr_a), 64'h0);
    check("rst_doe", 64'(doe_a), 64'h0);
    check("rst_dout", 64'(dout_a), 64'h0);
    check("rst_ack", 64'(bus_a.ack_o), 64'h0);
    check("rst_rdata", 64'(bus_a.rdata_o), 64'h0);
    check("rst_busy", 64'(busy_a), 64'h0);
    rst_a = 1'b1;
    rst_b = 1'b1;
    @(posedge clk); #1;

    // A: single read, channel 0
    din_a = 32'hDEADBEEF;
    bus_a.req_i = 4'b0001;
    bus_a.addr_i[0 +: AW] = 20'h00010;
    @(negedge clk);
    check("rd_gnt", 64'(bus_a.gnt_o), 64'h1);
    @(posedge clk); #1;
    bus_a.req_i = '0;
    @(negedge clk);
    check("rd_oe_n", 64'(oe_n_a), 64'h0);
    check("rd_ce_n", 64'(ce_n_a), 64'h0);
    check("rd_we_n", 64'(we_n_a), 64'h1);
    check("rd_addr", 64'(addr_a), 64'h10);
    check("rd_doe", 64'(doe_a), 64'h0);
    check("rd_ack_early", 64'(bus_a.ack_o), 64'h0);
    @(negedge clk);
    check("rd_ack", 64'(bus_a.ack_o), 64'h1);
    check("rd_rdata", 64'(bus_a.rdata_o), 64'hDEADBEEF);
    check("rd_hold_oe_n", 64'(oe_n_a), 64'h1);
    check("rd_hold_ce_n", 64'(ce_n_a), 64'h0);
    @(negedge clk);
    check("rd_idle_busy", 64'(busy_a), 64'h0);
    check("rd_idle_ce_n", 64'(ce_n_a), 64'h1);

    // A: write, channel 1, partial byte enables
    @(posedge clk); #1;
    din_a = 32'h0BAD_F00D;
    bus_a.req_i = 4'b0010;
    bus_a.we_i  = 4'b0010;
    bus_a.addr_i[AW +: AW]  = 20'hFFFFF;
    bus_a.wdata_i[DW +: DW] = 32'h12345678;
    bus_a.be_i[4 +: 4]      = 4'b0011;
    @(negedge clk);
    check("wr_gnt", 64'(bus_a.gnt_o), 64'h2);
    @(posedge clk); #1;
    bus_a.req_i = '0;
    bus_a.we_i  = '0;
    @(negedge clk);
    check("wr_we_n", 64'(we_n_a), 64'h0);
    check("wr_oe_n", 64'(oe_n_a), 64'h1);
    check("wr_be_n", 64'(be_n_a), 64'hC);
    check("wr_doe", 64'(doe_a), 64'h1);
    check("wr_dout", 64'(dout_a), 64'h12345678);
    check("wr_addr", 64'(addr_a), 64'hFFFFF);
    @(negedge clk);
    check("wr_hold_we_n", 64'(we_n_a), 64'h1);
    check("wr_hold_ce_n", 64'(ce_n_a), 64'h0);
    check("wr_hold_doe", 64'(doe_a), 64'h1);
    check("wr_hold_be_n", 64'(be_n_a), 64'hC);
    check("wr_ack", 64'(bus_a.ack_o), 64'h2);
    check("wr_rdata_kept", 64'(bus_a.rdata_o), 64'hDEADBEEF);
    @(negedge clk);
    check("wr_idle_doe", 64'(doe_a), 64'h0);
    check("wr_idle_ce_n", 64'(ce_n_a), 64'h1);

    // A: fixed priority with all channels requesting
    @(posedge clk); #1;
    bus_a.req_i = 4'b1111;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      check("fp_gnt", 64'(bus_a.gnt_o), (c % 3 == 0) ? 64'h1 : 64'h0);
    end
    @(posedge clk); #1;
    bus_a.req_i = '0;

    // B: round-robin, WAIT_CYC=3, back-to-back reads
    din_b = 32'hA5A50001;
    bus_b.req_i = 4'b1111;
    oe_low = 0;
    for (int c = 0; c <= 20; c++) begin
      @(negedge clk);
      check("rr_gnt", 64'(bus_b.gnt_o), (c % 5 == 0) ? (64'h1 << ((c / 5) % 4)) : 64'h0);
      if (c % 5 == 4) check("rr_ack", 64'(bus_b.ack_o), 64'h1 << ((c / 5) % 4));
      if (c == 4) check("rr_rdata", 64'(bus_b.rdata_o), 64'hA5A50001);
      if (c < 20 && oe_n_b == 1'b0) oe_low++;
    end
    check("rr_oe_low_cycles", 64'(oe_low), 64'd12);
    @(posedge clk); #1;
    bus_b.req_i = '0;
    repeat (5) @(posedge clk);
    #1;

    // B: reset in the middle of a write, then pointer must be back at ch0-first
    bus_b.req_i = 4'b0100;
    bus_b.we_i  = 4'b0100;
    bus_b.be_i  = '1;
    bus_b.wdata_i[2*DW +: DW] = 32'hCAFE0002;
    @(negedge clk);
    check("rst_wr_gnt", 64'(bus_b.gnt_o), 64'h4);
    @(posedge clk); #1;
    bus_b.req_i = '0;
    bus_b.we_i  = '0;
    @(negedge clk);
    check("rst_wr_we_n", 64'(we_n_b), 64'h0);
    #2 rst_b = 1'b0;
    #1;
    check("abort_we_n", 64'(we_n_b), 64'h1);
    check("abort_ce_n", 64'(ce_n_b), 64'h1);
    check("abort_oe_n", 64'(oe_n_b), 64'h1);
    check("abort_doe", 64'(doe_b), 64'h0);
    check("abort_busy", 64'(busy_b), 64'h0);
    @(posedge clk); #1;
    rst_b = 1'b1;
    acks = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus_b.ack_o != '0) acks++;
    end
    check("abort_no_ack", 64'(acks), 64'd0);
    @(posedge clk); #1;
    bus_b.req_i = 4'b1111;
    @(negedge clk);
    check("post_rst_gnt", 64'(bus_b.gnt_o), 64'h1);
    @(posedge clk); #1;
    bus_b.req_i = '0;

`ifdef SRAM_ARB_STATS_EN
    // A: two channels requesting continuously for 10 cycles
    bus_a.req_i = 4'b0011;
    repeat (10) @(posedge clk);
    #1;
    bus_a.req_i = '0;
    check("stall_cnt", 64'(stall_a), 64'(exp_stall_a));
`endif

    repeat (6) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
